// File: rtl/i2c_eeprom_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_eeprom_pkg
// Description : Shared types and constants for the I2C EEPROM target:
//               FSM state encoding, memory geometry and R/W bit encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_eeprom_pkg;

    localparam int MEM_DEPTH = 256;
    localparam int BYTE_BITS = 8;

    // Value of the LSB of the device-address byte
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_DEV       = 4'd1,
        ST_DEV_ACK   = 4'd2,
        ST_WADDR     = 4'd3,
        ST_WADDR_ACK = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RMACK     = 4'd8
    } state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// ============================================================================
// Module      : i2c_bus_sync
// Description : Synchronises SCL/SDA into the axil_aclk domain and derives
//               SCL edge strobes plus START/STOP conditions.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic axil_aclk,
    input  logic axil_aresetn,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic                   w_scl_s;

    // Synchroniser chains plus one delayed copy; reset to the idle (high) bus
    // level so that releasing reset never fabricates an edge or condition.
    always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
        if (!axil_aresetn) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_d    <= w_scl_s;
            r_sda_d    <= sda_s;
        end
    end

    assign w_scl_s  = r_scl_sync[SYNC_STAGES-1];
    assign sda_s    = r_sda_sync[SYNC_STAGES-1];
    assign scl_rise =  w_scl_s & ~r_scl_d;
    assign scl_fall = ~w_scl_s &  r_scl_d;
    // SCL must be high on both samples so an SDA change racing SCL is not
    // mistaken for a START/STOP.
    assign start    = w_scl_s & r_scl_d &  r_sda_d & ~sda_s;
    assign stop     = w_scl_s & r_scl_d & ~r_sda_d &  sda_s;

endmodule
`default_nettype wire

// File: rtl/i2c_eeprom_target.sv
`default_nettype none
// ============================================================================
// Module      : i2c_eeprom_target
// Description : I2C target with a 256-byte EEPROM-style memory. Supports
//               byte/page writes and current/random reads with an
//               auto-incrementing word pointer, oversampled on axil_aclk.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_eeprom_target
    import i2c_eeprom_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                 axil_aclk,
    input  logic                 axil_aresetn,
    input  logic                 scl_i,
    input  logic                 sda_i,
    output logic                 sda_oe,
    output logic                 busy,
    output logic                 wr_valid,
    output logic [BYTE_BITS-1:0] wr_addr,
    output logic [BYTE_BITS-1:0] wr_data
);

    logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda_s;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bus_sync (
        .axil_aclk    (axil_aclk),
        .axil_aresetn (axil_aresetn),
        .scl_i        (scl_i),
        .sda_i        (sda_i),
        .scl_rise     (w_scl_rise),
        .scl_fall     (w_scl_fall),
        .start        (w_start),
        .stop         (w_stop),
        .sda_s        (w_sda_s)
    );

    state_t               r_state, w_state_nxt;
    logic [2:0]           r_bit_cnt, w_bit_cnt_nxt;
    // Holds the first seven bits; the eighth is taken live from sda_s
    logic [BYTE_BITS-2:0] r_shift, w_shift_nxt;
    logic [BYTE_BITS-1:0] r_rd, w_rd_nxt;
    logic [BYTE_BITS-1:0] r_ptr, w_ptr_nxt;
    logic                 r_rw, w_rw_nxt;
    logic                 r_sda_oe, w_sda_oe_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_wr_valid, w_wr_valid_nxt;
    logic [BYTE_BITS-1:0] r_wr_addr, w_wr_addr_nxt;
    logic [BYTE_BITS-1:0] r_wr_data, w_wr_data_nxt;
    logic                 w_mem_we;
    logic [BYTE_BITS-1:0] w_byte;
    logic [BYTE_BITS-1:0] r_mem [MEM_DEPTH];
    logic [BYTE_BITS-1:0] r_mem_q;

    assign w_byte = {r_shift, w_sda_s};

    // Next-state and datapath decode; bus conditions override bit events
    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_rd_nxt       = r_rd;
        w_ptr_nxt      = r_ptr;
        w_rw_nxt       = r_rw;
        w_sda_oe_nxt   = r_sda_oe;
        w_busy_nxt     = r_busy;
        w_wr_valid_nxt = 1'b0;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_data_nxt  = r_wr_data;
        w_mem_we       = 1'b0;
        if (w_stop) begin
            w_state_nxt   = ST_IDLE;
            w_sda_oe_nxt  = 1'b0;
            w_busy_nxt    = 1'b0;
            w_bit_cnt_nxt = 3'd0;
        end else if (w_start) begin
            w_state_nxt   = ST_DEV;
            w_sda_oe_nxt  = 1'b0;
            w_bit_cnt_nxt = 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: ;
                ST_DEV, ST_WADDR, ST_WDATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_byte[BYTE_BITS-2:0];
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            if (r_state == ST_DEV) begin
                                if (w_byte[7:1] == DEV_ADDR) begin
                                    w_rw_nxt    = w_byte[0];
                                    w_busy_nxt  = 1'b1;
                                    w_state_nxt = ST_DEV_ACK;
                                end else begin
                                    w_state_nxt = ST_IDLE;
                                end
                            end else if (r_state == ST_WADDR) begin
                                w_ptr_nxt   = w_byte;
                                w_state_nxt = ST_WADDR_ACK;
                            end else begin
                                w_mem_we       = 1'b1;
                                w_wr_valid_nxt = 1'b1;
                                w_wr_addr_nxt  = r_ptr;
                                w_wr_data_nxt  = w_byte;
                                w_ptr_nxt      = r_ptr + 8'd1;
                                w_state_nxt    = ST_WDATA_ACK;
                            end
                        end
                    end
                end
                // First fall after the byte drives ACK, the second ends it
                ST_DEV_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_sda_oe) begin
                            w_sda_oe_nxt = 1'b1;
                        end else if (r_rw == RW_READ) begin
                            w_sda_oe_nxt  = ~r_mem_q[7];
                            w_rd_nxt      = {r_mem_q[6:0], 1'b0};
                            w_bit_cnt_nxt = 3'd0;
                            w_state_nxt   = ST_RDATA;
                        end else begin
                            w_sda_oe_nxt  = 1'b0;
                            w_bit_cnt_nxt = 3'd0;
                            w_state_nxt   = ST_WADDR;
                        end
                    end
                end
                ST_WADDR_ACK, ST_WDATA_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_sda_oe) begin
                            w_sda_oe_nxt = 1'b1;
                        end else begin
                            w_sda_oe_nxt  = 1'b0;
                            w_bit_cnt_nxt = 3'd0;
                            w_state_nxt   = ST_WDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt = ~r_rd[7];
                        w_rd_nxt     = {r_rd[6:0], 1'b0};
                    end else if (w_scl_rise) begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_ptr_nxt   = r_ptr + 8'd1;
                            w_state_nxt = ST_RMACK;
                        end
                    end
                end
                // Release after bit 0, then sample the controller's ACK/NACK
                ST_RMACK: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt = 1'b0;
                    end else if (w_scl_rise) begin
                        if (!w_sda_s) begin
                            w_rd_nxt      = r_mem_q;
                            w_bit_cnt_nxt = 3'd0;
                            w_state_nxt   = ST_RDATA;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Control and datapath registers
    always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
        if (!axil_aresetn) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 3'd0;
            r_shift    <= '0;
            r_rd       <= '0;
            r_ptr      <= '0;
            r_rw       <= RW_WRITE;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_rd       <= w_rd_nxt;
            r_ptr      <= w_ptr_nxt;
            r_rw       <= w_rw_nxt;
            r_sda_oe   <= w_sda_oe_nxt;
            r_busy     <= w_busy_nxt;
            r_wr_valid <= w_wr_valid_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
        end
    end

    // Single-port RAM: write on a completed data byte, registered read at ptr
    always_ff @(posedge axil_aclk) begin
        if (w_mem_we) begin
            r_mem[r_ptr] <= w_byte;
        end
        r_mem_q <= r_mem[r_ptr];
    end

    assign sda_oe   = r_sda_oe;
    assign busy     = r_busy;
    assign wr_valid = r_wr_valid;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;

endmodule
`default_nettype wire

// File: doc/i2c_eeprom_target.md
# i2c_eeprom_target

Synthesizable I2C target (slave) with a 256-byte EEPROM-style memory, sitting on the SCL/SDA bus directly downstream of the I2C master core in the AXI-Lite I2C IP. It replaces the behavioural bus model in co-simulation and FPGA loopback builds. It decodes START/STOP, matches a 7-bit device address, and ACKs address/data bytes. It supports byte/page writes and current/random (repeated-START) reads with an auto-incrementing word pointer, all oversampled on axil_aclk.

## Interface
- DEV_ADDR, 7'h50, 7-bit device address matched in the first byte after START.
- SYNC_STAGES, 2, flip-flop stages on scl_i/sda_i before edge detection (≥2).
- scl_i  input  1  bus SCL level (pull-up resolved).
- sda_i  input  1  bus SDA level (pull-up resolved).
- sda_oe  output  1  1 = pull SDA low; 0 = release. Pad is open-drain: sda = sda_oe ? 0 : Z.
- busy  output  1  high from an address-matched START until STOP or abort.
- wr_valid  output  1  one-cycle pulse per memory byte written.
- wr_addr  output  8  memory address of the write reported by wr_valid.
- wr_data  output  8  data of the write reported by wr_valid.

## Operation
- Synchronize scl_i/sda_i. Derive scl_rise/scl_fall from the synchronized SCL. START = synchronized SDA falls while SCL high; STOP = synchronized SDA rises while SCL high.
- Sample bits on scl_rise, MSB first, into an 8-bit shift register with a 3-bit bit counter. Change sda_oe only on scl_fall.
- States: IDLE, DEV, DEV_ACK, WADDR, WADDR_ACK, WDATA, WDATA_ACK, RDATA, RMACK.
- IDLE: ignore the bus until START, then go to DEV.
- DEV: after 8 bits, if byte[7:1]==DEV_ADDR, assert sda_oe on the next scl_fall and go to DEV_ACK. Otherwise return to IDLE with no ACK.
- DEV_ACK: on the scl_fall ending the ACK bit, release SDA.
  - If R/W=0, go to WADDR.
  - If R/W=1, load the read shift register from mem[ptr] and go to RDATA, driving bit 7 at that same scl_fall.
- WADDR: after 8 bits, set ptr = byte and ACK (WADDR_ACK), then go to WDATA.
- WDATA: after 8 bits, write mem[ptr], pulse wr_valid with wr_addr=ptr and wr_data=byte, set ptr=ptr+1 (mod 256, wraps 0xFF→0x00), and ACK (WDATA_ACK). Return to WDATA for further bytes.
- RDATA: on each scl_fall set sda_oe = ~bit. After the 8th bit, release SDA, set ptr=ptr+1, and go to RMACK.
- RMACK: on scl_rise sample the master's ACK.
  - SDA=0 (ACK): load mem[ptr] and go to RDATA.
  - SDA=1 (NACK): go to IDLE (release SDA, wait for STOP/START).
- START in any state (repeated START) aborts the current byte, releases SDA, and goes to DEV. ptr is kept, so a random read is WADDR write followed by repeated-START read.
- STOP in any state: release SDA, go to IDLE, drop busy. A partial byte is discarded; a partial WDATA byte is never written.
- START/STOP take priority over a same-cycle scl_rise/scl_fall.
- Memory is not reset; contents are undefined until written. ptr resets to 0.

## Timing
- Reset (async, axil_aresetn low): sda_oe=0, busy=0, wr_valid=0, wr_addr=0, wr_data=0, state IDLE, ptr=0, bit counter 0. Asserting reset mid-transfer releases SDA in the same instant.
- Pin-to-event latency: SYNC_STAGES+1 cycles.
- sda_oe changes SYNC_STAGES+1 cycles after the pin scl_fall, registered.
- wr_valid asserts 1 cycle after the scl_rise that samples the 8th data bit.
- Required bus timing: SCL high and SCL low each ≥ 4 axil_aclk cycles, and SDA setup/hold around SCL edges ≥ SYNC_STAGES+1 cycles. Behaviour outside these limits is unspecified.
- Memory read is registered: mem[ptr] is fetched in the cycle after the decision, always before the next scl_fall given the above limits.

## Structure
- i2c_eeprom_pkg holds:
  - the state enum typedef;
  - localparams MEM_DEPTH=256 and BYTE_BITS=8;
  - the R/W bit encoding.
- One sub-module, i2c_bus_sync: synchronizer, SCL edge detect, and START/STOP detect, with outputs scl_rise, scl_fall, start, stop, sda_s.
- Top level holds the FSM, shift register, ptr, and an 8x256 memory (inferable RAM, single write port, registered read).

## Test plan
- Write 0x50/W, waddr 0x10, data 0x31,0x32,0x33,0x34, STOP -> four ACKs after data plus the address ACKs; wr_valid pulses with (0x10,0x31)..(0x13,0x34); busy falls at STOP.
- Random read: 0xA0, 0x10, repeated START, 0xA1, read 4 bytes (ACK,ACK,ACK,NACK) -> SDA returns 0x31,0x32,0x33,0x34; sda_oe=0 during master ACK/NACK bits.
- Address 0x51 written -> no ACK (SDA high at 9th clock), busy stays 0, no wr_valid.
- Write at waddr 0xFE with 3 data bytes -> writes land at 0xFE, 0xFF, 0x00.
- STOP after 5 bits of a data byte -> no wr_valid; the following current-address read returns the byte at the unchanged ptr.
- axil_aresetn asserted while driving a read 0 bit -> sda_oe=0 immediately; after release the next transaction is ACKed normally.
